// File: rtl/pulse_period_meter_pkg.sv
// Shared divider/meter definitions: measurement FSM states, default datapath
// width and the counter-width helper used to size saturating counters.
package div_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } meas_state_t;

  localparam int unsigned DEF_WIDTH = 32;

  // Bits needed to hold values 0..max_val (never less than one bit).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pulse_period_meter_if.sv
// Measurement bus of pulse_period_meter: control/stimulus in, period report out.
interface pulse_period_meter_if
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
);
  logic             en;
  logic             pulse_in;
  logic [WIDTH-1:0] expected;
  logic [WIDTH-1:0] period;
  logic             period_valid;
  logic             match;
  logic             lock;
  logic             timeout;

  modport master (
    output en, pulse_in, expected,
    input  period, period_valid, match, lock, timeout
  );

  modport slave (
    input  en, pulse_in, expected,
    output period, period_valid, match, lock, timeout
  );
endinterface

// File: rtl/pulse_period_meter_cmp.sv
// Period comparator: exact equality by default, |measured-expected| <= tol
// when PERIOD_TOL_EN is defined. An expected value of zero never matches.
module period_window_cmp #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] measured,
  input  logic [WIDTH-1:0] expected,
  input  logic [WIDTH-1:0] tol,
  output logic             match
);

`ifdef PERIOD_TOL_EN
  logic [WIDTH:0] diff;

  // One extra bit keeps the magnitude exact whichever operand is larger.
  always_comb begin
    if (measured >= expected) begin
      diff = {1'b0, measured} - {1'b0, expected};
    end else begin
      diff = {1'b0, expected} - {1'b0, measured};
    end
    match = (expected != '0) && (diff <= {1'b0, tol});
  end
`else
  logic unused_tol;
  assign unused_tol = ^tol;

  always_comb begin
    match = (expected != '0) && (measured == expected);
  end
`endif

endmodule

// File: rtl/pulse_period_meter.sv
// Measures clock cycles between rising edges of pulse_in, checks against
// expected, tracks lock and timeout. Optional tolerance compare: PERIOD_TOL_EN.
module pulse_period_meter
  import div_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned MAX_PERIOD = 1000000,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned TOL        = 2
) (
  input logic                  clk,
  input logic                  rst,
  pulse_period_meter_if.slave  bus
);

  localparam int unsigned MCW = cnt_width(LOCK_COUNT);

  meas_state_t      state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [MCW-1:0]   match_cnt_q, match_cnt_d;
  logic             pulse_d_q;
  logic [WIDTH-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             match_q, match_d;
  logic             lock_q, lock_d;
  logic             timeout_q, timeout_d;

  logic rise;
  logic cmp_match;

  assign rise = bus.pulse_in & ~pulse_d_q;

  period_window_cmp #(
    .WIDTH (WIDTH)
  ) u_cmp (
    .measured (count_q),
    .expected (bus.expected),
    .tol      (WIDTH'(TOL)),
    .match    (cmp_match)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    match_cnt_d = match_cnt_q;
    period_d    = period_q;
    valid_d     = 1'b0;
    match_d     = match_q;
    lock_d      = lock_q;
    timeout_d   = timeout_q;

    // Disable overrides both a measuring edge and a pending timeout.
    if (!bus.en) begin
      state_d     = IDLE;
      count_d     = '0;
      match_cnt_d = '0;
      lock_d      = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rise) begin
            state_d = ARMED;
            count_d = WIDTH'(1);
          end
        end
        ARMED: begin
          if (rise) begin
            period_d  = count_q;
            count_d   = WIDTH'(1);
            valid_d   = 1'b1;
            timeout_d = 1'b0;
            match_d   = cmp_match;
            if (cmp_match) begin
              if (match_cnt_q != MCW'(LOCK_COUNT)) begin
                match_cnt_d = match_cnt_q + MCW'(1);
              end
            end else begin
              match_cnt_d = '0;
            end
            lock_d = (match_cnt_d == MCW'(LOCK_COUNT));
          end else if (count_q == WIDTH'(MAX_PERIOD)) begin
            state_d     = IDLE;
            count_d     = '0;
            match_cnt_d = '0;
            lock_d      = 1'b0;
            timeout_d   = 1'b1;
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      match_cnt_q <= '0;
      pulse_d_q   <= 1'b0;
      period_q    <= '0;
      valid_q     <= 1'b0;
      match_q     <= 1'b0;
      lock_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      match_cnt_q <= match_cnt_d;
      pulse_d_q   <= bus.pulse_in;
      period_q    <= period_d;
      valid_q     <= valid_d;
      match_q     <= match_d;
      lock_q      <= lock_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.period       = period_q;
  assign bus.period_valid = valid_q;
  assign bus.match        = match_q;
  assign bus.lock         = lock_q;
  assign bus.timeout      = timeout_q;

endmodule

// File: tb/tb_pulse_period_meter.sv
// Bench for pulse_period_meter: directed scenarios plus random pulse streams,
// every cycle compared against an edge-timestamp reference model.
module tb_pulse_period_meter;

  localparam int unsigned WIDTH      = 32;
  localparam int unsigned MAX_PERIOD = 100;
  localparam int unsigned LOCK_COUNT = 4;
  localparam int unsigned TOL        = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  pulse_period_meter_if #(.WIDTH(WIDTH)) bus ();

  pulse_period_meter #(
    .WIDTH      (WIDTH),
    .MAX_PERIOD (MAX_PERIOD),
    .LOCK_COUNT (LOCK_COUNT),
    .TOL        (TOL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: remembers when the arming edge happened and derives
  // periods/timeouts from elapsed cycle counts.
  int  cyc      = 0;
  bit  m_armed  = 0;
  int  m_t0     = 0;
  bit  m_prev   = 0;
  int  m_streak = 0;
  int  m_period = 0;
  bit  m_valid  = 0;
  bit  m_match  = 0;
  bit  m_lock   = 0;
  bit  m_tout   = 0;

  function automatic bit model_match(input int p, input int e);
    if (e == 0) return 1'b0;
`ifdef PERIOD_TOL_EN
    return ((p > e) ? (p - e) : (e - p)) <= int'(TOL);
`else
    return p == e;
`endif
  endfunction

  task automatic model_step();
    bit rise;
    int p;
    if (rst) begin
      m_armed = 0; m_prev = 0; m_streak = 0; m_period = 0;
      m_valid = 0; m_match = 0; m_lock = 0; m_tout = 0;
    end else begin
      rise    = bus.pulse_in && !m_prev;
      m_prev  = bus.pulse_in;
      m_valid = 0;
      if (!bus.en) begin
        m_armed = 0; m_streak = 0; m_lock = 0;
      end else if (!m_armed) begin
        if (rise) begin
          m_armed = 1; m_t0 = cyc;
        end
      end else if (rise) begin
        p        = cyc - m_t0;
        m_period = p;
        m_valid  = 1;
        m_tout   = 0;
        m_match  = model_match(p, int'(bus.expected));
        m_streak = m_match ? ((m_streak + 1 > int'(LOCK_COUNT)) ? int'(LOCK_COUNT) : m_streak + 1) : 0;
        m_lock   = (m_streak == int'(LOCK_COUNT));
        m_t0     = cyc;
      end else if (cyc - m_t0 == int'(MAX_PERIOD)) begin
        m_tout = 1; m_lock = 0; m_streak = 0; m_armed = 0;
      end
    end
    cyc++;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("period",       64'(bus.period),       64'(m_period));
    check("period_valid", 64'(bus.period_valid), 64'(m_valid));
    check("match",        64'(bus.match),        64'(m_match));
    check("lock",         64'(bus.lock),         64'(m_lock));
    check("timeout",      64'(bus.timeout),      64'(m_tout));
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // n rising edges spaced gap cycles apart, single-cycle high pulse.
  task automatic pulses(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      bus.pulse_in = 1'b1;
      tick();
      bus.pulse_in = 1'b0;
      idle_ticks(gap - 1);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.pulse_in = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int gap, width, sel;
    bus.en       = 1'b0;
    bus.pulse_in = 1'b0;
    bus.expected = '0;

    do_reset();
    check("rst_period",  64'(bus.period), 64'd0);
    check("rst_lock",    64'(bus.lock), 64'd0);
    check("rst_timeout", 64'(bus.timeout), 64'd0);

    // Steady 10-cycle stream reaches lock on the fifth edge.
    bus.en = 1'b1;
    bus.expected = 32'd10;
    pulses(5, 10);
    check("lock_after_5_edges", 64'(bus.lock), 64'd1);
    check("period_10",          64'(bus.period), 64'd10);

    // One long interval breaks lock, which returns after four good strobes.
    pulses(1, 11);
    pulses(1, 10);
    check("period_11",   64'(bus.period), 64'd11);
    check("match_11",    64'(bus.match), 64'd0);
    check("lock_broken", 64'(bus.lock), 64'd0);
    pulses(5, 10);
    check("relock", 64'(bus.lock), 64'd1);

    // Stream stops: timeout at MAX_PERIOD, then recovery with 20-cycle edges.
    idle_ticks(120);
    check("timeout_set",  64'(bus.timeout), 64'd1);
    check("timeout_lock", 64'(bus.lock), 64'd0);
    bus.expected = 32'd20;
    pulses(3, 20);
    check("period_20",     64'(bus.period), 64'd20);
    check("timeout_clear", 64'(bus.timeout), 64'd0);

    // Edge exactly MAX_PERIOD after arming is a measurement, not a timeout.
    do_reset();
    bus.expected = 32'd100;
    pulses(2, 100);
    check("period_max",  64'(bus.period), 64'd100);
    check("no_timeout",  64'(bus.timeout), 64'd0);

    // Enable dropped mid-interval.
    bus.expected = 32'd10;
    pulses(5, 10);
    bus.pulse_in = 1'b1; tick(); bus.pulse_in = 1'b0;
    idle_ticks(3);
    bus.en = 1'b0; idle_ticks(3); bus.en = 1'b1;
    idle_ticks(3);
    pulses(4, 10);
    check("no_lock_after_en", 64'(bus.lock), 64'd0);
    pulses(1, 10);
    check("lock_after_en", 64'(bus.lock), 64'd1);

    // Tolerance window stimulus.
    pulses(1, 12); pulses(1, 8); pulses(1, 13); pulses(1, 10);

    // expected = 0 never matches.
    bus.expected = '0;
    pulses(3, 7);
    check("exp0_match", 64'(bus.match), 64'd0);

    // Random streams with occasional enable drops, resets and long gaps.
    for (int it = 0; it < 150; it++) begin
      gap   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(95, 106)) : int'($urandom_range(2, 30));
      width = int'($urandom_range(1, gap - 1));
      sel   = int'($urandom_range(0, 7));
      case (sel)
        0, 1, 2: bus.expected = 32'(gap);
        3:       bus.expected = 32'(gap + 1);
        4:       bus.expected = 32'(gap - 1);
        5:       bus.expected = 32'(gap + 2);
        6:       bus.expected = '0;
        default: bus.expected = 32'($urandom_range(1, 120));
      endcase
      for (int k = 0; k < gap; k++) begin
        bus.pulse_in = (k < width);
        bus.en       = ($urandom_range(0, 199) != 0);
        rst          = ($urandom_range(0, 999) == 0);
        tick();
      end
      rst = 1'b0;
      bus.en = 1'b1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pulse_period_meter.md
Name: pulse_period_meter

Overview:
- Receive-side counterpart of the team's clock/pulse divider: measures the clock-cycle interval between rising edges of a pulse stream.
- Reports each measured period and compares it against an expected divide ratio.
- Flags lock after consecutive matches and flags timeout when the pulse stream stops.
- Sits beside the divider for self-check/BIST and for monitoring externally generated ticks synchronous to clk.

Parameters:
WIDTH, 32, width of period, expected and internal counter
MAX_PERIOD, 1000000, cycle count at which an armed measurement times out (1..2^WIDTH-1)
LOCK_COUNT, 4, consecutive matching periods required to assert lock (>=1)
TOL, 2, allowed |period-expected| when PERIOD_TOL_EN is defined

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
en  input  1  measurement enable
pulse_in  input  1  pulse stream, synchronous to clk
expected  input  WIDTH  expected period in cycles, sampled at each measurement
period  output  WIDTH  last measured period (held until next measurement)
period_valid  output  1  one-cycle strobe: period updated
match  output  1  last measured period matched expected (held)
lock  output  1  LOCK_COUNT consecutive matches seen
timeout  output  1  sticky: MAX_PERIOD reached without an edge

Behaviour:
- Reset (sync, active-high, one clock, single clock domain): state=IDLE, count=0, match_cnt=0, pulse_d=0, all outputs 0. A pulse_in high in the first cycle after reset counts as a rise.
- rise = pulse_in & ~pulse_d. pulse_d <= pulse_in every cycle regardless of en.
- States: IDLE, ARMED.
- IDLE: on rise with en=1 -> ARMED, count<=1. No period_valid on this first edge.
- ARMED, no rise, count<MAX_PERIOD: count<=count+1.
- ARMED, rise at cycle t1 (previous rise at t0):
  - period<=count (=t1-t0); count<=1; stay ARMED.
  - period_valid=1 in cycle t1+1 only; match, lock, timeout update in that same cycle.
  - timeout<=0.
- ARMED, no rise, count==MAX_PERIOD: timeout<=1, lock<=0, match_cnt<=0, -> IDLE. period and match are held.
- Rise coincident with count==MAX_PERIOD: measurement wins; period=MAX_PERIOD, no timeout.
- Match test, exact compare: match = (count == expected). expected=0 never matches.
- match_cnt:
  - On match, match_cnt <= min(match_cnt+1, LOCK_COUNT).
  - On mismatch, match_cnt<=0 and lock<=0 in the same update.
  - lock = (next match_cnt == LOCK_COUNT).
- en=0 (synchronous, takes priority over rise and timeout): -> IDLE, count<=0, match_cnt<=0, lock<=0. period, match and timeout are held; period_valid=0.
- rst mid-measurement: everything returns to reset values next cycle; the partial count is discarded.
- Counter never wraps: the timeout path bounds it at MAX_PERIOD.

Optional Feature:
- PERIOD_TOL_EN defined: match = (|count - expected| <= TOL). The difference is computed at WIDTH+1 bits, so there is no underflow when count<expected.
- PERIOD_TOL_EN undefined: exact equality only. TOL is unused and no subtractor is synthesized.

Decomposition:
- Package div_pkg:
  - state enum meas_state_t {IDLE, ARMED}
  - default WIDTH constant
  - localparam-derived count width helper shared with the divider
- One sub-module, period_window_cmp (combinational): inputs measured, expected, tol; output match. Contains the exact/tolerance compare under PERIOD_TOL_EN.

Test Plan:
- Single-cycle pulse every 10 clks, expected=10 -> first edge arms; period_valid every 10 clks with period=10, match=1; lock=1 on 4th period_valid (5th edge).
- Locked stream, one interval of 11 then 10s -> that strobe shows period=11, match=0, lock=0; lock re-asserts 4 strobes later.
- MAX_PERIOD=100, arm then no pulses -> at count 100: timeout=1, lock=0, state IDLE. Later edges 20 apart -> period=20, period_valid once, timeout=0.
- MAX_PERIOD=100, second rise exactly 100 clks after first -> period=100, period_valid=1, timeout stays 0.
- en dropped for 3 clks mid-interval, then pulses every 10 -> no strobe for the broken interval. First post-en edge only arms; next strobe period=10; lock only after 4 fresh matches.
- PERIOD_TOL_EN, TOL=2, expected=10, intervals 12, 8, 13 -> match=1,1,0. Undefined build, same stimulus -> match=0,0,0.
